// File: rtl/keypad_time_encoder.sv
// Keypad to BCD time-entry encoder: sync, optional debounce, shift-in digits.
// Optional build macro: MICROWAVE_DEBOUNCE_EN (adds DEBOUNCE state + counter).
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   keypad     in   [9:0] raw key lines, bit n = digit key n, async to clk
//   enable     in   1 = entry allowed; 0 = commits ignored, FSM still tracks keys
//   clear      in   synchronous clear of digits and digit count
//   units_sec  out  [3:0] BCD seconds units
//   tens_sec   out  [3:0] BCD seconds tens
//   minutes    out  [3:0] BCD minutes
//   key_valid  out  one-cycle pulse per committed key
//   full       out  three digits entered
//   time_valid out  tens_sec <= 5 (combinational)
//
// Parameter:
//   DEBOUNCE_CYCLES  stable cycles before commit (>=1), debounce build only
module keypad_time_encoder #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] keypad,
  input  logic       enable,
  input  logic       clear,
  output logic [3:0] units_sec,
  output logic [3:0] tens_sec,
  output logic [3:0] minutes,
  output logic       key_valid,
  output logic       full,
  output logic       time_valid
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_WAIT     = 2'd2
  } state_t;

  // Two-flop synchroniser; r_sync2 is the "ks" key vector.
  logic [9:0] r_sync1;
  logic [9:0] r_sync2;

  state_t     r_state;

  logic [3:0] r_units;
  logic [3:0] r_tens;
  logic [3:0] r_mins;
  logic [1:0] r_count;
  logic       r_full;
  logic       r_key_valid;

  logic       w_onehot;
  logic [3:0] w_code;
  logic       w_commit;

`ifdef MICROWAVE_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [9:0]    r_key_hold;
  logic [CW-1:0] r_cnt;
  logic          w_match;
`else
  localparam int unused_debounce = DEBOUNCE_CYCLES;
`endif

  // Exactly one key down; multi-key chords are ignored.
  always_comb begin
    w_onehot = (r_sync2 != 10'd0) &&
               ((r_sync2 & (r_sync2 - 10'd1)) == 10'd0);
  end

  // One-hot to BCD; only meaningful when w_onehot.
  always_comb begin
    w_code = 4'd0;
    for (int n = 0; n < 10; n++) begin
      if (r_sync2[n]) begin
        w_code = 4'(n);
      end
    end
  end

`ifdef MICROWAVE_DEBOUNCE_EN
  always_comb begin
    w_match  = (r_sync2 == r_key_hold);
    w_commit = (r_state == S_DEBOUNCE) && w_match &&
               (r_cnt == CNT_LAST);
  end
`else
  always_comb begin
    w_commit = (r_state == S_IDLE) && w_onehot;
  end
`endif

  // Synchroniser and key-tracking FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1    <= 10'd0;
      r_sync2    <= 10'd0;
      r_state    <= S_IDLE;
`ifdef MICROWAVE_DEBOUNCE_EN
      r_key_hold <= 10'd0;
      r_cnt      <= '0;
`endif
    end else begin
      r_sync1 <= keypad;
      r_sync2 <= r_sync1;
      case (r_state)
        S_IDLE: begin
          if (w_onehot) begin
`ifdef MICROWAVE_DEBOUNCE_EN
            r_key_hold <= r_sync2;
            r_cnt      <= '0;
            r_state    <= S_DEBOUNCE;
`else
            r_state    <= S_WAIT;
`endif
          end
        end
`ifdef MICROWAVE_DEBOUNCE_EN
        S_DEBOUNCE: begin
          if (!w_match) begin
            r_state <= S_IDLE;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= S_WAIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif
        S_WAIT: begin
          // A held key commits once; wait for all keys up.
          if (r_sync2 == 10'd0) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Digit shift register, digit count and key_valid pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_units     <= 4'd0;
      r_tens      <= 4'd0;
      r_mins      <= 4'd0;
      r_count     <= 2'd0;
      r_full      <= 1'b0;
      r_key_valid <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      if (clear) begin
        // Clear wins; a same-edge commit is dropped entirely.
        r_units <= 4'd0;
        r_tens  <= 4'd0;
        r_mins  <= 4'd0;
        r_count <= 2'd0;
        r_full  <= 1'b0;
      end else if (w_commit && enable) begin
        r_key_valid <= 1'b1;
        if (!r_full) begin
          r_mins  <= r_tens;
          r_tens  <= r_units;
          r_units <= w_code;
          r_count <= r_count + 2'd1;
          r_full  <= (r_count == 2'd2);
        end
      end
    end
  end

  assign units_sec  = r_units;
  assign tens_sec   = r_tens;
  assign minutes    = r_mins;
  assign key_valid  = r_key_valid;
  assign full       = r_full;
  assign time_valid = (r_tens <= 4'd5);

endmodule

// File: tb/tb_keypad_time_encoder.sv
// Bench for keypad_time_encoder: per-cycle model compare plus
// directed literal checks on digits, pulses and latency.
module tb_keypad_time_encoder;

`ifdef MICROWAVE_DEBOUNCE_EN
  localparam int DC  = 4;
  localparam int LAT = 2 + DC;
  localparam int RUN = DC + 1;
`else
  localparam int DC  = 16;
  localparam int LAT = 2;
  localparam int RUN = 1;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] keypad;
  logic       enable;
  logic       clear;
  logic [3:0] units_sec;
  logic [3:0] tens_sec;
  logic [3:0] minutes;
  logic       key_valid;
  logic       full;
  logic       time_valid;

  always #5 clk = ~clk;

  keypad_time_encoder #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk        (clk),
    .reset      (reset),
    .keypad     (keypad),
    .enable     (enable),
    .clear      (clear),
    .units_sec  (units_sec),
    .tens_sec   (tens_sec),
    .minutes    (minutes),
    .key_valid  (key_valid),
    .full       (full),
    .time_valid (time_valid)
  );

  int checks = 0;
  int errors = 0;
  int kv_seen = 0;
  bit run_chk = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: a key commits once it has been seen alone and unchanged
  // for RUN consecutive edges after the 2-cycle sync delay, and only
  // once per press (re-armed when all keys are up).
  logic [9:0] m_s1, m_s2, m_prev;
  int m_run, m_u, m_t, m_m, m_cnt;
  bit m_armed, m_kv;

  always @(posedge clk) begin : model
    logic [9:0] ks;
    bit oh, commit;
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_prev = 0;
      m_run = 0; m_armed = 1; m_kv = 0;
      m_u = 0; m_t = 0; m_m = 0; m_cnt = 0;
    end else begin
      ks = m_s2;
      oh = ($countones(ks) == 1);
      if (oh && ks == m_prev) m_run++;
      else m_run = oh ? 1 : 0;
      m_prev = ks;
      if (ks == 0) m_armed = 1;
      commit = m_armed && oh && (m_run == RUN);
      if (commit) m_armed = 0;
      m_kv = 0;
      if (clear) begin
        m_u = 0; m_t = 0; m_m = 0; m_cnt = 0;
      end else if (commit && enable) begin
        m_kv = 1;
        if (m_cnt < 3) begin
          m_m = m_t; m_t = m_u; m_u = $clog2(ks);
          m_cnt++;
        end
      end
      m_s2 = m_s1;
      m_s1 = keypad;
    end
  end

  always @(negedge clk) begin
    if (run_chk && !reset) begin
      chk("units", units_sec, m_u);
      chk("tens", tens_sec, m_t);
      chk("minutes", minutes, m_m);
      chk("key_valid", key_valid, m_kv);
      chk("full", full, m_cnt == 3);
      chk("time_valid", time_valid, m_t <= 5);
      if (key_valid) kv_seen++;
    end
  end

  task automatic press(input logic [9:0] k, input int hold);
    @(negedge clk);
    keypad = k;
    repeat (hold) @(negedge clk);
    keypad = 10'd0;
    repeat (6) @(negedge clk);
  endtask

  int base;
  int lat;
  bit got;

  initial begin
    reset = 1; keypad = 0; enable = 1; clear = 0;
    repeat (2) @(negedge clk);
    chk("rst_units", units_sec, 0);
    chk("rst_tens", tens_sec, 0);
    chk("rst_minutes", minutes, 0);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_full", full, 0);
    chk("rst_time_valid", time_valid, 1);
    reset = 0;
    run_chk = 1;

    // 1,3,0 -> 1:30
    base = kv_seen;
    press(10'd1 << 1, 10);
    press(10'd1 << 3, 10);
    press(10'd1 << 0, 10);
    chk("t2_minutes", minutes, 1);
    chk("t2_tens", tens_sec, 3);
    chk("t2_units", units_sec, 0);
    chk("t2_full", full, 1);
    chk("t2_pulses", kv_seen - base, 3);

    // fourth key while full
    base = kv_seen;
    press(10'd1 << 5, 10);
    chk("t3_minutes", minutes, 1);
    chk("t3_tens", tens_sec, 3);
    chk("t3_units", units_sec, 0);
    chk("t3_full", full, 1);
    chk("t3_pulses", kv_seen - base, 1);

`ifdef MICROWAVE_DEBOUNCE_EN
    base = kv_seen;
    press(10'd1 << 7, 2);
    chk("t4_bounce_pulses", kv_seen - base, 0);
`endif

    // commit latency from first sampling edge e0
    got = 0; lat = -1;
    @(negedge clk);
    keypad = 10'd1 << 7;
    for (int e = 0; e < 40 && !got; e++) begin
      @(posedge clk);
      #1;
      if (key_valid) begin
        got = 1;
        lat = e;
      end
    end
    chk("t4_latency", lat, LAT);
    keypad = 10'd0;
    repeat (6) @(negedge clk);

    // chord ignored; long hold commits once
    base = kv_seen;
    press((10'd1 << 2) | (10'd1 << 4), 10);
    chk("t5_chord_pulses", kv_seen - base, 0);
    base = kv_seen;
    press(10'd1 << 8, 50);
    chk("t5_hold_pulses", kv_seen - base, 1);

    // disabled entry
    enable = 0;
    base = kv_seen;
    press(10'd1 << 6, 10);
    enable = 1;
    chk("en0_pulses", kv_seen - base, 0);
    chk("en0_units", units_sec, 0);

    // clear on the commit edge of key 9
    @(negedge clk);
    keypad = 10'd1 << 9;
    repeat (LAT) @(negedge clk);
    clear = 1;
    @(negedge clk);
    clear = 0;
    repeat (8) @(negedge clk);
    keypad = 10'd0;
    repeat (6) @(negedge clk);
    chk("t6_units", units_sec, 0);
    chk("t6_tens", tens_sec, 0);
    chk("t6_minutes", minutes, 0);
    chk("t6_full", full, 0);

    press(10'd1 << 9, 10);
    press(10'd1 << 9, 10);
    chk("t6_tens99", tens_sec, 9);
    chk("t6_units99", units_sec, 9);
    chk("t6_time_valid", time_valid, 0);
    chk("t6_full99", full, 0);

    // reset mid-debounce / mid-hold, key still held
    base = kv_seen;
    @(negedge clk);
    keypad = 10'd1 << 4;
    repeat (LAT - 1) @(negedge clk);
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (20) @(negedge clk);
    keypad = 10'd0;
    repeat (6) @(negedge clk);
    chk("rst_hold_pulses", kv_seen - base, 1);
    chk("rst_hold_units", units_sec, 4);
    chk("rst_hold_tens", tens_sec, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
